// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the serial add/subtract sequencer
package serial_add_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one full_adder cell
// Optional feature macro: SERIAL_ADD_OVF_EN (registers signed overflow on ovf; otherwise ovf = 0)
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   op       : 0 = add, 1 = subtract (latched with start)
//   a, b     : WIDTH-bit operands (latched with start)
//   busy     : high while the bit steps are running
//   done     : one-cycle pulse when result/cout/ovf are updated
//   result   : WIDTH-bit sum or difference
//   cout     : carry out of MSB (subtract: 1 = no borrow)
//   ovf      : two's-complement overflow flag
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state, next_state;
  logic [WIDTH-1:0] sa, sb, sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_c;
  logic             load, step, last;

  full_adder u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last = (cnt == LAST);
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last) next_state = S_DONE;
      end
      S_DONE: begin
        // A start here chains straight into the next operation.
        if (start) begin
          load       = 1'b1;
          next_state = S_RUN;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      sa     <= a;
      // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
      sb     <= (op == OP_ADD) ? b : ~b;
      sum_sr <= '0;
      carry  <= (op == OP_SUB);
      cnt    <= '0;
    end else if (step) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_c;
      cnt    <= cnt + 1'b1;
      if (last) begin
        // Outputs only ever change here, so partial sums never appear.
        result <= {fa_s, sum_sr[WIDTH-1:1]};
        cout   <= fa_c;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // On the last step the carry flop holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf_r <= 1'b0;
    else if (step && last) ovf_r <= carry ^ fa_c;
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with a behavioural model
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: returns {ovf, cout, result}.
  function automatic logic [WIDTH+1:0] model_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic o);
    int unsigned      sx, sy, full;
    logic [WIDTH-1:0] r;
    logic             c, v;
    sx = x;
    sy = y;
    if (!o) begin
      full = sx + sy;
      r    = WIDTH'(full);
      c    = (full >= (32'd1 << WIDTH));
      v    = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end else begin
      full = sx - sy;
      r    = WIDTH'(full);
      c    = (sx >= sy);
      v    = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end
    if (!OVF_EN) v = 1'b0;
    return {v, c, r};
  endfunction

  // Model: an accepted request takes WIDTH cycles, then results appear with a done pulse.
  int               m_left;
  logic             m_done, m_cout, m_ovf, p_cout, p_ovf;
  logic [WIDTH-1:0] m_res, p_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= p_res;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        {p_ovf, p_cout, p_res} <= model_op(a, b, op);
        m_left <= WIDTH;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy",   busy,   m_left > 0);
      check("done",   done,   m_done);
      check("result", result, m_res);
      check("cout",   cout,   m_cout);
      check("ovf",    ovf,    m_ovf);
    end
  end

  // One operation with hand-computed expectations; optionally fires a stray start mid-run.
  task automatic do_op(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic top, input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                       input bit inject);
    int lat, bc, extra;
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      if (inject && lat == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; op = ~top;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({nm, " latency"}, lat, WIDTH);
    check({nm, " busy_cycles"}, bc, WIDTH);
    check({nm, " lit_result"}, result, er);
    check({nm, " lit_cout"}, cout, ec);
    check({nm, " lit_ovf"}, ovf, OVF_EN ? eo : 1'b0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({nm, " extra_done"}, extra, 0);
  endtask

  initial begin
    int n;
    int dcount;
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, dcount;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst cout", cout, 0);
    check("rst ovf", ovf, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("no done after rst", done, 0);

    do_op("add3c05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    do_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    do_op("sub0506", 8'h05, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    do_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_op("stray_start", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); op = 1'b0; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 40);
      check("b2b spacing", n, WIDTH + 1);
      a = 8'($urandom);
      b = 8'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 8'h12; b = 8'h34; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async result", result, 0);
    check("async cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort no done", dcount, 0);
    do_op("after_rst", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);

    // Random traffic, including starts during runs.
    dcount = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (done) dcount++;
      start = ($urandom_range(0, 2) == 0);
      op    = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
    end
    start = 1'b0;
    check("random ops completed", dcount > 20, 1);
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
